// File: rtl/key_event_queue_pkg.sv
// key_pkg: shared definitions for the key event queue.
//   - 3-bit key codes produced by the PS/2 keyboard decoder
//   - auto-repeat FSM state encoding
//   - helper to test a code against a repeat mask
package key_pkg;

   localparam int unsigned KEY_W = 3;

   localparam logic [KEY_W-1:0] KEY_NONE  = 3'd0;
   localparam logic [KEY_W-1:0] KEY_ESC   = 3'd1;
   localparam logic [KEY_W-1:0] KEY_SPACE = 3'd2;
   localparam logic [KEY_W-1:0] KEY_CW    = 3'd3;
   localparam logic [KEY_W-1:0] KEY_CCW   = 3'd4;
   localparam logic [KEY_W-1:0] KEY_LEFT  = 3'd5;
   localparam logic [KEY_W-1:0] KEY_RIGHT = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } rep_state_e;

   // Bit k of the mask set means key code k auto-repeats while held.
   function automatic logic is_repeatable(input logic [KEY_W-1:0] code,
                                          input logic [7:0]       mask);
      return mask[code];
   endfunction

endpackage

// File: rtl/key_event_queue_if.sv
// key_event_queue_if: consumer-side bundle of the key event queue.
//   evt_valid    - FIFO non-empty (registered)
//   evt_key      - head event code, 0 when empty (registered)
//   count        - entries held, 0..DEPTH
//   overflow     - sticky: an event was dropped on a full FIFO
//   pop          - consumer takes the head event this cycle
//   clr_overflow - clears overflow
// Modports: master = the queue, slave = the consuming game logic.
interface key_event_queue_if #(
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic                      evt_valid;
   logic [key_pkg::KEY_W-1:0] evt_key;
   logic [CW-1:0]             count;
   logic                      overflow;
   logic                      pop;
   logic                      clr_overflow;

   modport master (
      output evt_valid, evt_key, count, overflow,
      input  pop, clr_overflow
   );

   modport slave (
      input  evt_valid, evt_key, count, overflow,
      output pop, clr_overflow
   );

endinterface

// File: rtl/key_event_queue_event_fifo.sv
// event_fifo: synchronous FIFO of key event codes.
//   clk, rst_n  - clock, synchronous active-low reset (flushes everything)
//   push        - enqueue push_data this cycle
//   push_data   - event code to enqueue
//   pop         - dequeue request; ignored while empty
//   head_valid  - registered non-empty flag
//   head_data   - registered head code, 0 when empty
//   count       - registered entry count, 0..DEPTH
//   drop        - combinational: this cycle's push was discarded (full, no pop)
// A push together with a pop is accepted even when full; a pop on an empty
// FIFO is ignored even if a push lands in the same cycle.
module event_fifo
   import key_pkg::*;
#(
   parameter int unsigned DEPTH = 8
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [KEY_W-1:0]         push_data,
   input  logic                     pop,
   output logic                     head_valid,
   output logic [KEY_W-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     drop
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [KEY_W-1:0] mem_q [DEPTH];
   logic [KEY_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             head_valid_q, head_valid_d;
   logic [KEY_W-1:0] head_data_q, head_data_d;

   logic do_push;
   logic do_pop;
   logic full;

   always_comb begin
      do_pop  = pop && (count_q != '0);
      full    = (count_q == CW'(DEPTH));
      do_push = push && (!full || do_pop);
      drop    = push && full && !do_pop;

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Head is taken from the post-update storage so a push into an empty
      // FIFO and a pop both show their effect on the very next edge.
      head_valid_d = (count_d != '0);
      head_data_d  = head_valid_d ? mem_d[rd_ptr_d] : KEY_NONE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         head_valid_q <= 1'b0;
         head_data_q  <= KEY_NONE;
      end else begin
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         head_valid_q <= head_valid_d;
         head_data_q  <= head_data_d;
      end
   end

   assign head_valid = head_valid_q;
   assign head_data  = head_data_q;
   assign count      = count_q;

endmodule

// File: rtl/key_event_queue.sv
// key_event_queue: turns the level-style key code from the keyboard decoder
// into discrete buffered key events (press + auto-repeat) for game logic.
//   clk    - system clock
//   rst_n  - synchronous active-low reset; discards all state
//   key    - raw 3-bit key code, asynchronous to clk, 0 = no key
//   evt    - consumer bundle (evt_valid, evt_key, count, overflow,
//            pop, clr_overflow)
// Pipeline: 2-flop synchroniser -> key_q + edge detect / repeat FSM ->
// registered push -> event_fifo with registered head.
module key_event_queue
   import key_pkg::*;
#(
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned REPEAT_DELAY = 25_000_000,
   parameter int unsigned REPEAT_RATE  = 10_000_000,
   parameter logic [7:0]  REPEAT_MASK  = 8'b0110_0100
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [KEY_W-1:0]     key,
   key_event_queue_if.master    evt
);

   logic [KEY_W-1:0] sync1_q, sync1_d;
   logic [KEY_W-1:0] sync2_q, sync2_d;
   logic [KEY_W-1:0] key_q, key_d;
   rep_state_e       state_q, state_d;
   logic [31:0]      rep_cnt_q, rep_cnt_d;
   logic             push_q, push_d;
   logic [KEY_W-1:0] push_key_q, push_key_d;
   logic             overflow_q, overflow_d;

   logic             press;
   logic             changed;
   logic             rep_fire;

   logic                   fifo_valid;
   logic [KEY_W-1:0]       fifo_head;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   fifo_drop;

   // Input synchroniser and press detection
   always_comb begin
      sync1_d = key;
      sync2_d = sync1_q;
      key_d   = sync2_q;
      changed = (sync2_q != key_q);
      press   = changed && (sync2_q != KEY_NONE);
   end

   // Repeat FSM: any change of the synchronised code (release or a new
   // code) restarts it, so a press and a repeat never share a cycle.
   always_comb begin
      state_d   = state_q;
      rep_cnt_d = rep_cnt_q;
      rep_fire  = 1'b0;

      if (press && is_repeatable(sync2_q, REPEAT_MASK)) begin
         state_d   = ST_DELAY;
         rep_cnt_d = 32'(REPEAT_DELAY - 1);
      end else if (changed) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_DELAY, ST_REPEAT: begin
               if (rep_cnt_q == '0) begin
                  rep_fire  = 1'b1;
                  state_d   = ST_REPEAT;
                  rep_cnt_d = 32'(REPEAT_RATE - 1);
               end else begin
                  rep_cnt_d = rep_cnt_q - 32'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Registered push stage and sticky overflow (a new drop wins over clear)
   always_comb begin
      push_d     = press || rep_fire;
      push_key_d = press ? sync2_q : (rep_fire ? key_q : KEY_NONE);
      overflow_d = (overflow_q && !evt.clr_overflow) || fifo_drop;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q    <= KEY_NONE;
         sync2_q    <= KEY_NONE;
         key_q      <= KEY_NONE;
         state_q    <= ST_IDLE;
         rep_cnt_q  <= '0;
         push_q     <= 1'b0;
         push_key_q <= KEY_NONE;
         overflow_q <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         key_q      <= key_d;
         state_q    <= state_d;
         rep_cnt_q  <= rep_cnt_d;
         push_q     <= push_d;
         push_key_q <= push_key_d;
         overflow_q <= overflow_d;
      end
   end

   event_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push_q),
      .push_data  (push_key_q),
      .pop        (evt.pop),
      .head_valid (fifo_valid),
      .head_data  (fifo_head),
      .count      (fifo_count),
      .drop       (fifo_drop)
   );

   assign evt.evt_valid = fifo_valid;
   assign evt.evt_key   = fifo_head;
   assign evt.count     = fifo_count;
   assign evt.overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
module tb_key_event_queue;
   import key_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned RD    = 20;
   localparam int unsigned RR    = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [KEY_W-1:0] key = '0;
   logic             pop_mon = 1'b0;
   logic             pop_stim = 1'b0;
   logic             clr = 1'b0;

   key_event_queue_if #(.DEPTH(DEPTH)) evt ();

   assign evt.pop          = pop_mon | pop_stim;
   assign evt.clr_overflow = clr;

   key_event_queue #(
      .DEPTH        (DEPTH),
      .REPEAT_DELAY (RD),
      .REPEAT_RATE  (RR),
      .REPEAT_MASK  (8'b0110_0100)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .key   (key),
      .evt   (evt)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [KEY_W-1:0] exp_q[$];
   bit auto_pop = 1'b0;

   // push edges / codes for the current profile, hand-derived
   int               pe[$];
   logic [KEY_W-1:0] pc[$];

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: pops and scores the head whenever draining is enabled.
   initial forever begin
      @(negedge clk);
      pop_mon = 1'b0;
      if (auto_pop && evt.evt_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual=%0d required=none", evt.evt_key);
         end else begin
            chk("event_key", int'(evt.evt_key), int'(exp_q.pop_front()));
         end
         pop_mon = 1'b1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Drives a key sequence and checks count/valid/head every cycle.
   // Cycle c = number of rising edges since the first drive; drives at
   // cycle c are sampled by edge c+1. rst_at is the reset edge (0 = none).
   task automatic run_profile(input string name, input logic [KEY_W-1:0] c1,
                              input int chg_at, input logic [KEY_W-1:0] c2,
                              input int rel_at, input int rst_at, input int total);
      int exp_cnt;
      logic [KEY_W-1:0] head;
      for (int i = 0; i < pe.size(); i++) begin
         if (rst_at == 0 || pe[i] > rst_at) exp_q.push_back(pc[i]);
      end
      for (int c = 0; c <= total; c++) begin
         if (c > 0) begin
            step(1);
            exp_cnt = 0;
            head    = '0;
            for (int j = 0; j < pe.size(); j++) begin
               if (pe[j] + 1 <= c && (rst_at == 0 || c < rst_at || pe[j] > rst_at)) begin
                  if (exp_cnt == 0) head = pc[j];
                  exp_cnt++;
               end
            end
            chk({name, "_count"}, int'(evt.count), exp_cnt);
            chk({name, "_valid"}, int'(evt.evt_valid), int'(exp_cnt != 0));
            if (exp_cnt != 0) chk({name, "_head"}, int'(evt.evt_key), int'(head));
         end
         if (c == 0) key = c1;
         if (chg_at > 0 && c == chg_at) key = c2;
         if (c == rel_at) key = '0;
         if (rst_at > 0 && c == rst_at - 1) rst_n = 1'b0;
         if (rst_at > 0 && c == rst_at) rst_n = 1'b1;
      end
   endtask

   task automatic drain(input string name);
      bit done = 1'b0;
      auto_pop = 1'b1;
      for (int i = 0; i < 60 && !done; i++) begin
         step(1);
         if (exp_q.size() == 0 && !evt.evt_valid) done = 1'b1;
      end
      auto_pop = 1'b0;
      chk({name, "_drain_done"}, int'(done), 1);
      chk({name, "_drain_left"}, exp_q.size(), 0);
      chk({name, "_drain_count"}, int'(evt.count), 0);
   endtask

   task automatic tap(input logic [KEY_W-1:0] code, input int on, input int off);
      key = code;
      step(on);
      key = '0;
      step(off);
   endtask

   initial begin
      // Reset then idle
      step(3);
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step(1);
         chk("idle_valid", int'(evt.evt_valid), 0);
         chk("idle_key", int'(evt.evt_key), 0);
         chk("idle_count", int'(evt.count), 0);
         chk("idle_overflow", int'(evt.overflow), 0);
      end

      // Single tap of a non-repeating key
      pe = '{3};
      pc = '{3'd3};
      run_profile("tap", 3'd3, 0, 3'd0, 10, 0, 15);
      drain("tap");

      // Auto-repeat of LEFT held 50 cycles
      pe = '{3, 23, 28, 33, 38, 43, 48};
      pc = '{3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5};
      run_profile("repeat5", 3'd5, 0, 3'd0, 50, 0, 55);
      drain("repeat5");

      // ESC held 50 cycles does not repeat
      pe = '{3};
      pc = '{3'd1};
      run_profile("hold1", 3'd1, 0, 3'd0, 50, 0, 55);
      drain("hold1");

      // LEFT -> RIGHT without release; delay restarts from the RIGHT press
      pe = '{3, 13, 33};
      pc = '{3'd5, 3'd6, 3'd6};
      run_profile("change", 3'd5, 10, 3'd6, 35, 0, 45);
      drain("change");

      // Overflow: 9 taps, 8 kept
      for (int i = 0; i < 8; i++) exp_q.push_back(3'd4);
      for (int i = 0; i < 9; i++) tap(3'd4, 3, 3);
      step(3);
      chk("full_count", int'(evt.count), 8);
      chk("full_overflow", int'(evt.overflow), 1);
      chk("full_valid", int'(evt.evt_valid), 1);
      chk("full_head", int'(evt.evt_key), 4);

      // push (code 3) and pop on the same edge while full
      key = 3'd3;
      step(3);
      pop_stim = 1'b1;
      chk("full_pop_head", int'(evt.evt_key), int'(exp_q.pop_front()));
      exp_q.push_back(3'd3);
      step(1);
      pop_stim = 1'b0;
      chk("full_pushpop_count", int'(evt.count), 8);
      chk("full_pushpop_overflow", int'(evt.overflow), 1);
      chk("full_pushpop_head", int'(evt.evt_key), 4);
      key = '0;
      step(3);

      // clear coinciding with a fresh drop keeps overflow set
      key = 3'd4;
      step(3);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      chk("clr_vs_drop_overflow", int'(evt.overflow), 1);
      key = '0;
      step(3);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      chk("clr_overflow", int'(evt.overflow), 0);
      chk("clr_count", int'(evt.count), 8);
      drain("overflow");
      chk("post_drain_overflow", int'(evt.overflow), 0);

      // Reset mid-hold of RIGHT at edge 12
      pe = '{3, 15, 35, 40};
      pc = '{3'd6, 3'd6, 3'd6, 3'd6};
      run_profile("rsthold", 3'd6, 0, 3'd0, 42, 12, 50);
      drain("rsthold");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
